// File: rtl/bmem_arbiter.sv
// bmem_arbiter: shares the single burst-memory port between the OoO core
// memory unit (port 0) and the pipelined core memory unit (port 1).
// Whole transactions are arbitrated. A write burst locks the port to its
// owner until the final beat is accepted. An owner FIFO routes each
// returning read burst back to the port that issued it.
// Build option: define BMEM_ARB_RR_EN for round-robin arbitration in IDLE.
// Without it, port 0 has fixed priority.
module bmem_arbiter #(
  parameter int BURST_LEN       = 4,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] p0_addr,
  input  logic        p0_read,
  input  logic        p0_write,
  input  logic [63:0] p0_wdata,
  output logic        p0_ready,
  output logic [31:0] p0_raddr,
  output logic [63:0] p0_rdata,
  output logic        p0_rvalid,
  input  logic [31:0] p1_addr,
  input  logic        p1_read,
  input  logic        p1_write,
  input  logic [63:0] p1_wdata,
  output logic        p1_ready,
  output logic [31:0] p1_raddr,
  output logic [63:0] p1_rdata,
  output logic        p1_rvalid,
  output logic [31:0] bmem_addr,
  output logic        bmem_read,
  output logic        bmem_write,
  output logic [63:0] bmem_wdata,
  input  logic        bmem_ready,
  input  logic [31:0] bmem_raddr,
  input  logic [63:0] bmem_rdata,
  input  logic        bmem_rvalid,
  output logic        resp_err
);

  localparam int BW = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam int AW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;

  typedef enum logic {IDLE, WBURST} state_t;

  state_t                     r_state;
  state_t                     w_state_nxt;
  logic                       r_owner;
  logic [BW-1:0]              r_wbeat;
  logic [MAX_OUTSTANDING-1:0] r_fifo;
  logic [AW-1:0]              r_wptr;
  logic [AW-1:0]              r_rptr;
  logic [AW:0]                r_count;
  logic [BW-1:0]              r_rbeat;
  logic                       r_resp_err;
`ifdef BMEM_ARB_RR_EN
  logic                       r_rr_ptr;
`endif

  logic        w_empty;
  logic        w_head;
  logic        w_pop;
  logic        w_push;
  logic        w_full;
  logic        w_p0_elig;
  logic        w_p1_elig;
  logic        w_sel;
  logic        w_drive;
  logic        w_sel_write;
  logic        w_sel_read;
  logic [31:0] w_sel_addr;
  logic [63:0] w_sel_wdata;
  logic        w_acc;
  logic        w_rd_acc;
  logic        w_wr_acc;
  logic        w_burst_done;
  logic [AW-1:0] w_wptr_nxt;
  logic [AW-1:0] w_rptr_nxt;

  // Owner FIFO status; a slot freed by the final beat of the head burst
  // can be reused by a read accepted in that same cycle.
  assign w_empty = (r_count == '0);
  assign w_head  = r_fifo[r_rptr];
  assign w_pop   = bmem_rvalid && !w_empty && (r_rbeat == BW'(BURST_LEN - 1));
  assign w_full  = (r_count == (AW+1)'(MAX_OUTSTANDING)) && !w_pop;

  // Write takes precedence over read on the same port, so a writing port is
  // eligible even when the FIFO has no room. Nothing is granted in reset.
  assign w_p0_elig = rst && (p0_write || (p0_read && !w_full));
  assign w_p1_elig = rst && (p1_write || (p1_read && !w_full));

  // Grant selection and next state: IDLE arbitrates, WBURST follows the owner.
  always_comb begin
    w_sel       = 1'b0;
    w_drive     = 1'b0;
    w_state_nxt = r_state;
    case (r_state)
      IDLE: begin
        w_drive = w_p0_elig || w_p1_elig;
        if (w_p0_elig && w_p1_elig) begin
`ifdef BMEM_ARB_RR_EN
          w_sel = r_rr_ptr;
`else
          w_sel = 1'b0;
`endif
        end else begin
          w_sel = w_p1_elig;
        end
        if (w_wr_acc) w_state_nxt = WBURST;
      end
      WBURST: begin
        w_sel   = r_owner;
        w_drive = 1'b1;
        if (w_burst_done) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  assign w_sel_write = w_sel ? p1_write : p0_write;
  assign w_sel_read  = (w_sel ? p1_read : p0_read) && !w_sel_write && (r_state == IDLE);
  assign w_sel_addr  = w_sel ? p1_addr  : p0_addr;
  assign w_sel_wdata = w_sel ? p1_wdata : p0_wdata;

  assign bmem_addr  = w_drive ? w_sel_addr  : 32'h0;
  assign bmem_wdata = w_drive ? w_sel_wdata : 64'h0;
  assign bmem_read  = w_drive && w_sel_read;
  assign bmem_write = w_drive && w_sel_write;

  assign w_rd_acc     = bmem_ready && bmem_read;
  assign w_wr_acc     = bmem_ready && bmem_write;
  assign w_acc        = w_rd_acc || w_wr_acc;
  assign w_burst_done = (r_state == WBURST) && w_wr_acc && (r_wbeat == BW'(BURST_LEN - 1));
  assign w_push       = w_rd_acc;

  assign p0_ready = w_acc && !w_sel;
  assign p1_ready = w_acc &&  w_sel;

  // Response path is a pure broadcast; only the valid is steered by the head.
  assign p0_raddr  = bmem_raddr;
  assign p1_raddr  = bmem_raddr;
  assign p0_rdata  = bmem_rdata;
  assign p1_rdata  = bmem_rdata;
  assign p0_rvalid = bmem_rvalid && !w_empty && !w_head;
  assign p1_rvalid = bmem_rvalid && !w_empty &&  w_head;
  assign resp_err  = r_resp_err;

  assign w_wptr_nxt = (r_wptr == AW'(MAX_OUTSTANDING - 1)) ? '0 : r_wptr + 1'b1;
  assign w_rptr_nxt = (r_rptr == AW'(MAX_OUTSTANDING - 1)) ? '0 : r_rptr + 1'b1;

  // Arbiter state, burst owner and write beat count.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
      r_owner <= 1'b0;
      r_wbeat <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == IDLE && w_wr_acc) begin
        r_owner <= w_sel;
        r_wbeat <= BW'(1);
      end else if (w_burst_done) begin
        r_wbeat <= '0;
      end else if (r_state == WBURST && w_wr_acc) begin
        r_wbeat <= r_wbeat + 1'b1;
      end
    end
  end

`ifdef BMEM_ARB_RR_EN
  // Round-robin pointer moves to the other port after each completed grant.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rr_ptr <= 1'b0;
    end else if (w_rd_acc || w_burst_done) begin
      r_rr_ptr <= ~w_sel;
    end
  end
`endif

  // Owner FIFO payload: the issuing port of each accepted read.
  always_ff @(posedge clk) begin
    if (w_push) r_fifo[r_wptr] <= w_sel;
  end

  // Owner FIFO pointers, occupancy, head beat count and sticky error flag.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_count    <= '0;
      r_rbeat    <= '0;
      r_resp_err <= 1'b0;
    end else begin
      if (w_push) r_wptr <= w_wptr_nxt;
      if (w_pop)  r_rptr <= w_rptr_nxt;
      if (w_push && !w_pop)      r_count <= r_count + 1'b1;
      else if (!w_push && w_pop) r_count <= r_count - 1'b1;
      if (bmem_rvalid && !w_empty) r_rbeat <= w_pop ? '0 : r_rbeat + 1'b1;
      if (bmem_rvalid && w_empty)  r_resp_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_bmem_arbiter.sv
// Testbench for bmem_arbiter: randomized two-port traffic against a
// transaction-level reference model, with a scoreboard monitor.
`timescale 1ns/1ps
module tb_bmem_arbiter;
  localparam int BL = 4;
  localparam int MO = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] p0_addr, p1_addr, p0_raddr, p1_raddr, bmem_addr, bmem_raddr;
  logic [63:0] p0_wdata, p1_wdata, p0_rdata, p1_rdata, bmem_wdata, bmem_rdata;
  logic        p0_read, p0_write, p1_read, p1_write, p0_ready, p1_ready;
  logic        p0_rvalid, p1_rvalid, bmem_read, bmem_write, bmem_ready, bmem_rvalid;
  logic        resp_err;

  always #5 clk = ~clk;

  bmem_arbiter #(.BURST_LEN(BL), .MAX_OUTSTANDING(MO)) dut (
    .clk(clk), .rst(rst),
    .p0_addr(p0_addr), .p0_read(p0_read), .p0_write(p0_write), .p0_wdata(p0_wdata),
    .p0_ready(p0_ready), .p0_raddr(p0_raddr), .p0_rdata(p0_rdata), .p0_rvalid(p0_rvalid),
    .p1_addr(p1_addr), .p1_read(p1_read), .p1_write(p1_write), .p1_wdata(p1_wdata),
    .p1_ready(p1_ready), .p1_raddr(p1_raddr), .p1_rdata(p1_rdata), .p1_rvalid(p1_rvalid),
    .bmem_addr(bmem_addr), .bmem_read(bmem_read), .bmem_write(bmem_write),
    .bmem_wdata(bmem_wdata), .bmem_ready(bmem_ready), .bmem_raddr(bmem_raddr),
    .bmem_rdata(bmem_rdata), .bmem_rvalid(bmem_rvalid), .resp_err(resp_err)
  );

  typedef struct { int cyc; int port; bit rd; bit wr; logic [31:0] addr; logic [63:0] wdata; } req_t;
  typedef struct { int cyc; int port; logic [31:0] raddr; logic [63:0] rdata; } rsp_t;

  req_t q_req[$];
  rsp_t q_rsp[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   pc = 0;

  // Shadow inputs, applied to the DUT at the next falling edge.
  logic        s_rst;
  logic [31:0] s_addr[2];
  logic        s_read[2], s_write[2];
  logic [63:0] s_wdata[2];
  logic        s_bready, s_rvalid;
  logic [31:0] s_raddr;
  logic [63:0] s_rdata;

  // Reference model: transaction view of the arbiter.
  int m_lock;      // port holding an unfinished write burst, -1 if none
  int m_wbeats;    // beats accepted so far in that burst
  int m_pref;      // preferred port on a tie (round-robin build)
  int owners[$];   // ports with reads in flight, oldest first
  int m_hbeats;    // beats already returned for the oldest read
  bit m_err;
  bit acc[2];

  // Stimulus-side per-port transaction state.
  int pk[2];       // 0 idle, 1 read pending, 2 write pending
  int pb[2];       // write beats accepted

  always @(posedge clk) pc <= pc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, pc);
    end
  endtask

  task automatic model();
    bit wr[2], rd[2], el[2];
    bit pop_now, room;
    int g;
    req_t e;
    rsp_t r;
    acc[0] = 1'b0;
    acc[1] = 1'b0;
    if (!s_rst) begin
      m_lock = -1; m_wbeats = 0; m_pref = 0; owners.delete(); m_hbeats = 0; m_err = 1'b0;
    end else begin
      for (int p = 0; p < 2; p++) begin
        wr[p] = s_write[p];
        rd[p] = s_read[p] && !s_write[p];
      end
      pop_now = s_rvalid && owners.size() > 0 && m_hbeats == BL - 1;
      room    = owners.size() < MO || pop_now;
      g = -1;
      if (m_lock >= 0) begin
        if (wr[m_lock]) g = m_lock;
      end else begin
        for (int p = 0; p < 2; p++) el[p] = wr[p] || (rd[p] && room);
`ifdef BMEM_ARB_RR_EN
        if (el[0] && el[1]) g = m_pref;
`else
        if (el[0] && el[1]) g = 0;
`endif
        else if (el[0]) g = 0;
        else if (el[1]) g = 1;
      end
      if (s_rvalid) begin
        r.cyc = pc; r.raddr = s_raddr; r.rdata = s_rdata;
        if (owners.size() == 0) begin
          r.port = -1;
          m_err  = 1'b1;
        end else begin
          r.port = owners[0];
          m_hbeats++;
          if (m_hbeats == BL) begin
            owners.delete(0);
            m_hbeats = 0;
          end
        end
        q_rsp.push_back(r);
      end
      if (g >= 0 && s_bready) begin
        e.cyc = pc; e.port = g; e.rd = rd[g]; e.wr = wr[g];
        e.addr = s_addr[g]; e.wdata = s_wdata[g];
        q_req.push_back(e);
        acc[g] = 1'b1;
        if (rd[g]) begin
          owners.push_back(g);
          m_pref = 1 - g;
        end else begin
          m_lock = g;
          m_wbeats++;
          if (m_wbeats == BL) begin
            m_lock = -1; m_wbeats = 0; m_pref = 1 - g;
          end
        end
      end
    end
  endtask

  task automatic step();
    @(negedge clk);
    rst = s_rst;
    p0_addr = s_addr[0]; p0_read = s_read[0]; p0_write = s_write[0]; p0_wdata = s_wdata[0];
    p1_addr = s_addr[1]; p1_read = s_read[1]; p1_write = s_write[1]; p1_wdata = s_wdata[1];
    bmem_ready = s_bready; bmem_rvalid = s_rvalid; bmem_raddr = s_raddr; bmem_rdata = s_rdata;
    model();
  endtask

  task automatic clr();
    for (int p = 0; p < 2; p++) begin
      s_addr[p] = '0; s_read[p] = 1'b0; s_write[p] = 1'b0; s_wdata[p] = '0;
    end
    s_bready = 1'b0; s_rvalid = 1'b0; s_raddr = '0; s_rdata = '0;
  endtask

  task automatic gen(input int rsp_pct, input bit allow_new);
    for (int p = 0; p < 2; p++) begin
      if (pk[p] == 0 && allow_new && $urandom_range(99) < 40) begin
        pk[p] = ($urandom_range(99) < 55) ? 1 : 2;
        pb[p] = 0;
        s_addr[p] = $urandom & 32'hFFFF_FFC0;
      end
      s_read[p]  = (pk[p] == 1) || (pk[p] == 2 && $urandom_range(99) < 20);
      s_write[p] = (pk[p] == 2) && !(pb[p] > 0 && $urandom_range(99) < 15);
      s_wdata[p] = {$urandom, $urandom};
    end
    s_bready = ($urandom_range(99) < 70);
    s_rvalid = (owners.size() > 0) && ($urandom_range(99) < rsp_pct);
    s_raddr  = $urandom;
    s_rdata  = {$urandom, $urandom};
  endtask

  task automatic advance();
    for (int p = 0; p < 2; p++) begin
      if (acc[p]) begin
        if (pk[p] == 1) pk[p] = 0;
        else begin
          pb[p]++;
          if (pb[p] == BL) pk[p] = 0;
        end
      end
    end
  endtask

  // Scoreboard monitor: samples just before each rising edge.
  initial begin
    req_t e;
    rsp_t r;
    int   obs;
    forever begin
      @(negedge clk);
      #4;
      if ((bmem_ready && (bmem_read || bmem_write)) || p0_ready || p1_ready) begin
        if (q_req.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL req_unexpected: got transfer addr 0x%0h at cycle %0d, expected none", bmem_addr, pc);
        end else begin
          e = q_req.pop_front();
          obs = p0_ready ? (p1_ready ? 2 : 0) : (p1_ready ? 1 : 3);
          chk("req_cycle", pc, e.cyc);
          chk("req_port", obs, e.port);
          chk("req_rw", {bmem_ready, bmem_read, bmem_write}, {1'b1, e.rd, e.wr});
          chk("req_addr", bmem_addr, e.addr);
          chk("req_wdata", bmem_wdata, e.wdata);
        end
      end
      if (bmem_rvalid || p0_rvalid || p1_rvalid) begin
        if (q_rsp.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL rsp_unexpected: got rvalid %b%b at cycle %0d, expected none", p0_rvalid, p1_rvalid, pc);
        end else begin
          r = q_rsp.pop_front();
          chk("rsp_cycle", pc, r.cyc);
          chk("rsp_route", {bmem_rvalid, p0_rvalid, p1_rvalid}, {1'b1, r.port == 0, r.port == 1});
          chk("rsp_raddr", p1_raddr, r.raddr);
          chk("rsp_rdata", p0_rdata, r.rdata);
        end
      end
    end
  end

  initial begin
    int k;
    rst = 1'b1;
    p0_addr = '0; p0_read = 0; p0_write = 0; p0_wdata = '0;
    p1_addr = '0; p1_read = 0; p1_write = 0; p1_wdata = '0;
    bmem_ready = 0; bmem_rvalid = 0; bmem_raddr = '0; bmem_rdata = '0;
    pk[0] = 0; pk[1] = 0; pb[0] = 0; pb[1] = 0;
    clr();
    s_rst = 1'b0;
    repeat (3) step();
    #2;
    chk("reset_resp_err", resp_err, 0);
    chk("reset_bmem_rw", {bmem_read, bmem_write}, 0);
    chk("reset_ready", {p0_ready, p1_ready}, 0);
    chk("reset_bmem_addr", bmem_addr, 0);

    // Single read from port 0, then its four response beats.
    s_rst = 1'b1;
    s_addr[0] = 32'h1000; s_read[0] = 1'b1; s_bready = 1'b1;
    step();
    clr();
    for (int i = 0; i < BL; i++) begin
      s_rvalid = 1'b1; s_raddr = 32'h1000 + 32'(8 * i); s_rdata = 64'hA5A5_0000_0000_0000 + 64'(i);
      step();
    end
    clr();
    step();

    // Random traffic: moderate response rate, then a slow responder that
    // keeps the owner FIFO full, then drain everything.
    for (int i = 0; i < 800; i++) begin gen(50, 1'b1); step(); advance(); end
    for (int i = 0; i < 800; i++) begin gen(15, 1'b1); step(); advance(); end
    k = 0;
    while ((pk[0] != 0 || pk[1] != 0 || owners.size() > 0) && k < 400) begin
      gen(60, 1'b0); step(); advance(); k++;
    end
    if (k >= 400) begin
      n_cmp++; n_bad++;
      $display("FAIL drain_timeout: got %0d reads outstanding after %0d cycles, expected 0", owners.size(), k);
    end
    clr();
    step();
    #2;
    chk("resp_err_clean", resp_err, m_err);

    // Spurious response with nothing outstanding.
    s_rvalid = 1'b1; s_rdata = 64'hDEAD; step();
    clr(); step();
    #2;
    chk("resp_err_set", resp_err, m_err);
    step();
    #2;
    chk("resp_err_sticky", resp_err, m_err);

    // Reset in the middle of a port-1 write burst.
    s_addr[1] = 32'h2000; s_write[1] = 1'b1; s_bready = 1'b1;
    s_wdata[1] = 64'h1111; step();
    s_wdata[1] = 64'h2222; step();
    clr(); s_rst = 1'b0;
    step();
    #2;
    chk("midrst_bmem_rw", {bmem_read, bmem_write}, 0);
    chk("midrst_ready", {p0_ready, p1_ready}, 0);
    chk("midrst_resp_err", resp_err, m_err);
    chk("midrst_bmem_addr", bmem_addr, 0);
    s_rst = 1'b1; step();
    s_addr[0] = 32'h3000; s_read[0] = 1'b1; s_bready = 1'b1; step();
    clr();
    for (int i = 0; i < BL; i++) begin
      s_rvalid = 1'b1; s_rdata = 64'(i); step();
    end
    clr(); step();
    #6;
    chk("req_queue_left", q_req.size(), 0);
    chk("rsp_queue_left", q_rsp.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got no finish by 2 ms, expected completion");
    $fatal(1, "timeout");
  end
endmodule
